pipelined_cla_addsub: RTL and testbench

- Pipelined WIDTH-bit adder/subtractor built from 4-bit carry-look-ahead slices.
- Pipeline stage k resolves result bits [4k+3:4k], using the carry registered out of stage k-1.
- Adds valid/ready handshaking on both sides, so the datapath can sit between streaming producers and consumers.
- This is the sequential, bidirectional (add and subtract) successor to the combinational 4-bit CLA cells.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla4_addsub_slice.sv | 29 ++
 rtl/pipelined_cla_addsub.sv | 110 +++++++++++
 tb/tb_pipelined_cla_addsub.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, helpers and per-stage control token for the pipelined CLA adder/subtractor.
package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  function automatic int unsigned stages_of(int unsigned width);
    return width / SLICE_W;
  endfunction

  // Control half of a pipeline token; the data half is sized by the top-level WIDTH.
  typedef struct packed {
    logic valid;
    logic op_sub;
    logic carry;
    logic a_msb;
    logic beff_msb;
  } stage_ctl_t;

endpackage

// File: rtl/cla4_addsub_slice.sv
// Combinational 4-bit carry-look-ahead slice with group propagate/generate outputs.
module cla4_addsub_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic       g,
  output logic       p,
  output logic       co
);

  logic [3:0] gi;
  logic [3:0] pi;
  logic [3:0] ci;

  assign gi = a & b;
  assign pi = a ^ b;

  assign ci[0] = c;
  assign ci[1] = gi[0] | (pi[0] & c);
  assign ci[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c);
  assign ci[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & c);

  assign s  = pi ^ ci;
  assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign p  = &pi;
  assign co = g | (p & c);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one 4-bit CLA slice per stage, valid/ready on both sides.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned STAGES = stages_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // sum fills from the top as slices complete; a_rem/b_rem shift down so bits [3:0] feed the slice.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } token_t;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  token_t           last;

  assign b_eff = op_sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    token_t             src;
    token_t             nxt;
    token_t             q;
    logic [SLICE_W-1:0] s;
    logic               g;
    logic               p;
    logic               co;
    logic               unused_bits;

    if (k == 0) begin : g_src_in
      always_comb begin
        src              = '0;
        src.ctl.valid    = in_valid;
        src.ctl.op_sub   = op_sub;
        src.ctl.carry    = op_sub ? ~cin : cin;
        src.ctl.a_msb    = a[WIDTH-1];
        src.ctl.beff_msb = b_eff[WIDTH-1];
        src.a_rem        = a;
        src.b_rem        = b_eff;
      end
    end else begin : g_src_prev
      assign src = g_stage[k-1].q;
    end

    cla4_addsub_slice u_slice (
      .a  (src.a_rem[SLICE_W-1:0]),
      .b  (src.b_rem[SLICE_W-1:0]),
      .c  (src.ctl.carry),
      .s  (s),
      .g  (g),
      .p  (p),
      .co (co)
    );

    // Group P/G are exposed for a future multi-level look-ahead; the ripple between stages uses co.
    assign unused_bits = ^{g, p, src.sum[SLICE_W-1:0]};

    always_comb begin
      nxt           = src;
      nxt.ctl.carry = co;
      nxt.sum       = {s, src.sum[WIDTH-1:SLICE_W]};
      nxt.a_rem     = src.a_rem >> SLICE_W;
      nxt.b_rem     = src.b_rem >> SLICE_W;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q <= nxt;
      end
    end
  end

  assign last = g_stage[STAGES-1].q;

  logic unused_tail;
  assign unused_tail = ^{last.a_rem, last.b_rem};

  assign adv       = !last.ctl.valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = last.ctl.valid;
  assign sum       = last.sum;

  always_comb begin
    cout = last.ctl.valid & (last.ctl.op_sub ^ last.ctl.carry);
    ovf  = last.ctl.valid & (last.ctl.a_msb == last.ctl.beff_msb)
         & (last.sum[WIDTH-1] != last.ctl.a_msb);
    zero = last.ctl.valid & ~|last.sum;
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench: directed spec vectors, stall, mid-flight reset and randomized traffic.
module tb_pipelined_cla_addsub;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  pipelined_cla_addsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] res;  // {cout, ovf, zero, sum}
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          no_stall = 1'b0;
  bit          held = 1'b0;
  logic [18:0] prev_out;
  bit          rand_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [18:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                        input logic xc, input logic xs);
    int   sa;
    int   sb_;
    int   ua;
    int   ub;
    int   r;
    int   u;
    logic c;
    logic v;
    logic [15:0] s;
    sa  = int'($signed(xa));
    sb_ = int'($signed(xb));
    ua  = int'(xa);
    ub  = int'(xb);
    if (!xs) begin
      u = ua + ub + int'(xc);
      r = sa + sb_ + int'(xc);
      c = (u > 65535);
    end else begin
      u = ua - ub - int'(xc);
      r = sa - sb_ - int'(xc);
      c = (u < 0);
    end
    s = u[15:0];
    v = (r > 32767) || (r < -32768);
    return {c, v, (s == 16'h0000), s};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (held) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_out", {13'b0, cout, ovf, zero, sum}, {13'b0, prev_out});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", {13'b0, cout, ovf, zero, sum}, {13'b0, e.res});
          if (no_stall) check("latency", cyc - e.acc, LAT);
        end
      end
      held     = out_valid && !out_ready;
      prev_out = {cout, ovf, zero, sum};
    end
  end

  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic xs, input logic [18:0] res);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = xa;
    b        = xb;
    cin      = xc;
    op_sub   = xs;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.res = res;
        e.acc = cyc;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check(tag, {12'b0, out_valid, cout, ovf, zero, sum}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Directed vectors with spec-given results: {cout, ovf, zero, sum}.
    no_stall = 1'b1;
    send(16'h0005, 16'h0006, 1'b1, 1'b0, {3'b000, 16'h000C});
    send(16'h0005, 16'h0006, 1'b0, 1'b0, {3'b000, 16'h000B});
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {3'b101, 16'h0000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {3'b010, 16'h8000});
    send(16'h0005, 16'h0006, 1'b0, 1'b1, {3'b100, 16'hFFFF});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {3'b010, 16'h7FFF});
    repeat (6) @(posedge clk);
    #1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, {3'b000, 16'h3333});
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, {3'b000, 16'h1000});
    send(16'h1000, 16'h0001, 1'b0, 1'b1, {3'b000, 16'h0FFF});
    send(16'h0000, 16'h0000, 1'b0, 1'b0, {3'b001, 16'h0000});
    drain();

    // Stall: consumer blocked while six beats are offered.
    no_stall  = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [15:0] xa;
          logic [15:0] xb;
          xa = 16'(i * 16'h1357 + 16'h0101);
          xb = 16'(i * 16'h0F1F);
          send(xa, xb, 1'b0, 1'(i & 1), model(xa, xb, 1'b0, 1'(i & 1)));
        end
      end
      begin
        repeat (LAT + 3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with the pipeline full; nothing must emerge afterwards.
    no_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(16'(16'h0100 + i), 16'h0011, 1'b0, 1'b0,
                                     model(16'(16'h0100 + i), 16'h0011, 1'b0, 1'b0));
    check("full_before_reset", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_cleared("async_reset_clear");
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("after_reset_clear");
    send(16'h1234, 16'h4321, 1'b1, 1'b1, model(16'h1234, 16'h4321, 1'b1, 1'b1));
    drain();

    // Randomized traffic with random back-pressure.
    no_stall  = 1'b0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          logic [15:0] xa;
          logic [15:0] xb;
          logic        xc;
          logic        xs;
          xa = 16'($urandom);
          xb = 16'($urandom);
          if ($urandom_range(0, 7) == 0) xb = 16'h8000;
          if ($urandom_range(0, 7) == 0) xa = 16'hFFFF;
          xc = 1'($urandom);
          xs = 1'($urandom);
          send(xa, xb, xc, xs, model(xa, xb, xc, xs));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
